// File: rtl/node_integrator_multi.sv
// Charge-storage node: sums N branch currents, integrates into a saturating
// voltage, leaks when floating, and derives a hysteretic level and settled flag.
module node_integrator_multi #(
  parameter int W           = 16,
  parameter int N           = 4,
  parameter int SHIFT       = 0,
  parameter int HI          = 16384,
  parameter int LO          = -16384,
  parameter int TH_HI       = 4096,
  parameter int TH_LO       = -4096,
  parameter int INIT_D      = 0,
  parameter int LEAK_PERIOD = 8,
  parameter int LEAK_STEP   = 64,
  parameter int LEAK_TARGET = -16384,
  parameter int EPS         = 2,
  parameter int SETTLE      = 4
) (
  input  logic                eclk,
  input  logic                erst,
  input  logic [N*W-1:0]      i_bus,
  output logic signed [W-1:0] v,
  output logic                d,
  output logic                floating,
  output logic                settled
);

  localparam int SW = W + $clog2(N) + 1;
  localparam int VW = SW + 1;
  localparam int W1 = W + 1;
  localparam int FW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int CW = $clog2(SETTLE + 1);

  localparam logic signed [VW-1:0] VMAX =
    {{(VW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [VW-1:0] VMIN =
    {{(VW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] V_RST =
    (INIT_D != 0) ? W'(HI) : W'(LO);
  localparam logic signed [W-1:0] TH_HI_V = W'(TH_HI);
  localparam logic signed [W-1:0] TH_LO_V = W'(TH_LO);
  localparam logic signed [W1-1:0] TGT = W1'(LEAK_TARGET);
  localparam logic signed [W1-1:0] STEP = W1'(LEAK_STEP);
  localparam logic signed [W-1:0] STEP_V = W'(LEAK_STEP);
  localparam logic signed [W1-1:0] EPS_V = W1'(EPS);
  localparam logic [FW-1:0] F_LAST = FW'(LEAK_PERIOD - 1);
  localparam logic [CW-1:0] S_MAX = CW'(SETTLE);

  if (!(TH_LO < TH_HI && LO <= TH_LO && TH_HI <= HI)) begin : g_bad_th
    $error("node_integrator_multi: illegal threshold parameters");
  end

  logic        [FW-1:0] float_cnt;
  logic        [FW-1:0] cnt_next;
  logic        [CW-1:0] stable_cnt;
  logic        [CW-1:0] st_next;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] delta;
  logic signed [VW-1:0] acc;
  logic signed [W-1:0]  integ;
  logic signed [W1-1:0] ldiff;
  logic signed [W1-1:0] lmag;
  logic signed [W-1:0]  leak_v;
  logic signed [W-1:0]  v_next;
  logic signed [W1-1:0] chg;
  logic signed [W1-1:0] chg_mag;
  logic                 d_next;

  assign floating = (i_bus == '0);

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++)
      sum = sum + SW'($signed(i_bus[k*W +: W]));
  end

  assign delta = sum >>> SHIFT;
  assign acc   = VW'(v) + VW'(delta);

  always_comb begin
    if (acc > VMAX)
      integ = VMAX[W-1:0];
    else if (acc < VMIN)
      integ = VMIN[W-1:0];
    else
      integ = acc[W-1:0];
  end

  // Snap onto the target when within one step so the leak never overshoots.
  always_comb begin
    ldiff = W1'(v) - TGT;
    lmag  = (ldiff < 0) ? -ldiff : ldiff;
    if (lmag <= STEP)
      leak_v = TGT[W-1:0];
    else if (ldiff > 0)
      leak_v = v - STEP_V;
    else
      leak_v = v + STEP_V;
  end

  always_comb begin
    v_next   = v;
    cnt_next = float_cnt;
    if (!floating) begin
      v_next   = integ;
      cnt_next = '0;
    end else if (float_cnt == F_LAST) begin
      v_next   = leak_v;
      cnt_next = '0;
    end else begin
      cnt_next = float_cnt + FW'(1);
    end
  end

  always_comb begin
    d_next = d;
    if (v_next > TH_HI_V)
      d_next = 1'b1;
    else if (v_next < TH_LO_V)
      d_next = 1'b0;
  end

  always_comb begin
    chg     = W1'(v_next) - W1'(v);
    chg_mag = (chg < 0) ? -chg : chg;
    if (chg_mag > EPS_V)
      st_next = '0;
    else if (stable_cnt == S_MAX)
      st_next = stable_cnt;
    else
      st_next = stable_cnt + CW'(1);
  end

  always_ff @(posedge eclk) begin
    if (erst) begin
      v          <= V_RST;
      d          <= (INIT_D != 0);
      settled    <= 1'b0;
      float_cnt  <= '0;
      stable_cnt <= '0;
    end else begin
      v          <= v_next;
      d          <= d_next;
      settled    <= (st_next == S_MAX);
      float_cnt  <= cnt_next;
      stable_cnt <= st_next;
    end
  end

endmodule

// File: tb/tb_node_integrator_multi.sv
// Bench for node_integrator_multi: two instances (SHIFT=0 and SHIFT=2)
// driven by the same currents and compared against an integer node model.
module tb_node_integrator_multi;

  logic               eclk;
  logic               erst;
  logic [63:0]        i_bus;
  logic signed [15:0] v0, v1;
  logic               d0, d1, fl0, fl1, s0, s1;

  int checks = 0;
  int errors = 0;

  int ch [4];
  int mv [2];
  int md [2];
  int mf [2];
  int ms [2];
  int mset [2];
  int sh [2] = '{0, 2};

  node_integrator_multi #(.SHIFT(0)) dut0 (
    .eclk(eclk), .erst(erst), .i_bus(i_bus),
    .v(v0), .d(d0), .floating(fl0), .settled(s0)
  );

  node_integrator_multi #(.SHIFT(2)) dut1 (
    .eclk(eclk), .erst(erst), .i_bus(i_bus),
    .v(v1), .d(d1), .floating(fl1), .settled(s1)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Node physics in plain integer arithmetic.
  task automatic model_edge(input bit rst);
    int s, nv;
    bit fl;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        mv[u] = -16384; md[u] = 0; mf[u] = 0;
        ms[u] = 0; mset[u] = 0;
      end else begin
        s  = 0;
        fl = 1'b1;
        for (int k = 0; k < 4; k++) begin
          s += ch[k];
          if (ch[k] != 0) fl = 1'b0;
        end
        if (!fl) begin
          nv = mv[u] + (s >>> sh[u]);
          if (nv > 32767) nv = 32767;
          if (nv < -32768) nv = -32768;
          mf[u] = 0;
        end else if (mf[u] == 7) begin
          mf[u] = 0;
          if (iabs(mv[u] + 16384) <= 64) nv = -16384;
          else if (mv[u] > -16384) nv = mv[u] - 64;
          else nv = mv[u] + 64;
        end else begin
          mf[u]++;
          nv = mv[u];
        end
        if (nv > 4096) md[u] = 1;
        else if (nv < -4096) md[u] = 0;
        if (iabs(nv - mv[u]) <= 2) ms[u] = (ms[u] < 4) ? ms[u] + 1 : 4;
        else ms[u] = 0;
        mset[u] = (ms[u] == 4) ? 1 : 0;
        mv[u] = nv;
      end
    end
  endtask

  task automatic cycle(input bit rst);
    int fexp;
    erst = rst;
    for (int k = 0; k < 4; k++) i_bus[k*16 +: 16] = 16'(ch[k]);
    #1;
    fexp = (ch[0] == 0 && ch[1] == 0 && ch[2] == 0 && ch[3] == 0) ? 1 : 0;
    chk("floating0", int'(fl0), fexp);
    chk("floating1", int'(fl1), fexp);
    model_edge(rst);
    @(posedge eclk);
    #1;
    chk("v0", int'(v0), mv[0]);
    chk("d0", int'(d0), md[0]);
    chk("settled0", int'(s0), mset[0]);
    chk("v1", int'(v1), mv[1]);
    chk("d1", int'(d1), md[1]);
    chk("settled1", int'(s1), mset[1]);
  endtask

  task automatic set_ch(input int a, input int b, input int c, input int e);
    ch[0] = a; ch[1] = b; ch[2] = c; ch[3] = e;
  endtask

  initial begin
    erst  = 1'b1;
    i_bus = '0;
    set_ch(0, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      mv[u] = 0; md[u] = 0; mf[u] = 0; ms[u] = 0; mset[u] = 0;
    end

    // Reset and idle floating node sitting at the leak target
    cycle(1); cycle(1);
    chk("rst_v", int'(v0), -16384);
    chk("rst_settled", int'(s0), 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0);
      if (i == 3) chk("idle_settled4", int'(s0), 1);
    end
    chk("idle_v", int'(v0), -16384);

    // Ramp up with +1000, then down with -1000
    cycle(1);
    set_ch(1000, 0, 0, 0);
    for (int k = 1; k <= 25; k++) begin
      cycle(0);
      if (k == 20) begin
        chk("ramp_v20", int'(v0), 3616);
        chk("ramp_d20", int'(d0), 0);
      end
      if (k == 21) begin
        chk("ramp_v21", int'(v0), 4616);
        chk("ramp_d21", int'(d0), 1);
      end
    end
    set_ch(-1000, 0, 0, 0);
    for (int k = 0; k < 35; k++) cycle(0);

    // Saturation at both rails
    cycle(1);
    set_ch(32767, 32767, 32767, 32767);
    cycle(0);
    chk("sat_hi_v", int'(v0), 32767);
    chk("sat_hi_d", int'(d0), 1);
    set_ch(-32768, -32768, -32768, -32768);
    cycle(0);
    chk("sat_lo_v", int'(v0), -32768);
    chk("sat_lo_d", int'(d0), 0);

    // Leak from 100 down to the target
    cycle(1);
    set_ch(16484, 0, 0, 0);
    cycle(0);
    chk("leak_start", int'(v0), 100);
    set_ch(0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      cycle(0);
      if (k == 7) chk("leak_hold7", int'(v0), 100);
      if (k == 8) chk("leak_step8", int'(v0), 36);
    end
    for (int k = 0; k < 2100; k++) cycle(0);
    chk("leak_end", int'(v0), -16384);

    // Opposing currents: driven but frozen
    set_ch(16884, 0, 0, 0);
    cycle(0);
    set_ch(500, -500, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cycle(0);
      if (k == 4) chk("oppose_settled", int'(s0), 1);
    end
    chk("oppose_v", int'(v0), 500);

    // Reset mid-leak
    cycle(1);
    set_ch(18384, 0, 0, 0);
    cycle(0);
    chk("midleak_v", int'(v0), 2000);
    set_ch(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0);
    cycle(1);
    chk("midleak_rst_v", int'(v0), -16384);
    chk("midleak_rst_s", int'(s0), 0);
    set_ch(18384, 0, 0, 0);
    cycle(0);
    set_ch(0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cycle(0);

    // Arithmetic shift on the SHIFT=2 instance
    cycle(1);
    set_ch(-3, 0, 0, 0);
    cycle(0);
    chk("shift_neg", int'(v1), -16385);
    set_ch(3, 0, 0, 0);
    for (int k = 1; k <= 4; k++) cycle(0);
    chk("shift_pos", int'(v1), -16385);
    chk("shift_settled", int'(s1), 1);

    // Randomised mix of driven, opposing and floating cycles
    cycle(1);
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0, 1: set_ch(0, 0, 0, 0);
        2: begin
          ch[0] = int'($urandom_range(0, 4000)) - 2000;
          ch[1] = -ch[0];
          ch[2] = 0; ch[3] = 0;
        end
        3: for (int k = 0; k < 4; k++)
             ch[k] = int'($urandom_range(0, 65535)) - 32768;
        default: for (int k = 0; k < 4; k++)
             ch[k] = int'($urandom_range(0, 6)) - 3;
      endcase
      cycle($urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
